// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
// Single-byte I2C master sequencer. Each accepted command runs
// START, the address byte with the R/W bit, the slave ACK slot, then either
// one written byte plus its ACK slot or one read byte plus a master NACK,
// and finally STOP. A slave NACK on the address or write byte goes straight
// to STOP. Each bit slot is four quarter periods of SCL (P0..P3), and each
// quarter period lasts CLK_DIV clk cycles.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready command handshake; ready only while idle
//   cmd_addr, cmd_rw    7-bit slave address, 1 = read, 0 = write
//   cmd_wdata           byte to write
//   rdata               last successfully read byte
//   done, ack_err       end-of-transaction pulse and slave-NACK flag
//   busy                inverse of cmd_ready
//   inbar_out           1 = master drives SDA
//   iSCL, oSDA          SCL level and SDA drive value to the bus interface
//   iSDA                sampled SDA from the bus interface
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    output logic       inbar_out,
    output logic       iSCL,
    output logic       oSDA,
    input  logic       iSDA
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RNACK, STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_nxt;
    logic [7:0] div_cnt;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic [7:0] addr_byte;
    logic [7:0] wdata_reg;
    logic [7:0] rx_shift;
    logic       tick;
    logic       q_end;
    logic       sample;
    logic       accept;
    logic       last_bit;
    logic       bit_scl;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (state != IDLE) && (div_cnt == DIV_LAST);
    assign q_end     = tick && (quarter == 2'd3);
    // SDA is sampled on the tick that closes P2, while SCL is still high.
    assign sample    = tick && (quarter == 2'd2);
    assign last_bit  = (bit_cnt == 3'd0);
    assign bit_scl   = (quarter == 2'd1) || (quarter == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        iSCL      = 1'b1;
        oSDA      = 1'b1;
        inbar_out = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                // SDA falls while SCL is high, then SCL falls.
                oSDA      = (quarter < 2'd2);
                iSCL      = (quarter != 2'd3);
                inbar_out = 1'b1;
                if (q_end) state_nxt = ADDR;
            end
            ADDR: begin
                iSCL      = bit_scl;
                oSDA      = addr_byte[bit_cnt];
                inbar_out = 1'b1;
                if (q_end && last_bit) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                iSCL = bit_scl;
                // ack_err was already updated by the P2 sample of this slot.
                if (q_end) state_nxt = ack_err ? STOP : (addr_byte[0] ? RDATA : WDATA);
            end
            WDATA: begin
                iSCL      = bit_scl;
                oSDA      = wdata_reg[bit_cnt];
                inbar_out = 1'b1;
                if (q_end && last_bit) state_nxt = WDATA_ACK;
            end
            WDATA_ACK: begin
                iSCL = bit_scl;
                if (q_end) state_nxt = STOP;
            end
            RDATA: begin
                iSCL = bit_scl;
                if (q_end && last_bit) state_nxt = RNACK;
            end
            RNACK: begin
                iSCL      = bit_scl;
                inbar_out = 1'b1;
                if (q_end) state_nxt = STOP;
            end
            STOP: begin
                // SCL rises first, then SDA rises while SCL is high.
                oSDA      = quarter[1];
                iSCL      = (quarter != 2'd0);
                inbar_out = 1'b1;
                if (q_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            quarter <= 2'd0;
            bit_cnt <= 3'd7;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            if (state == IDLE || tick) div_cnt <= 8'd0;
            else                       div_cnt <= div_cnt + 8'd1;

            if (state == IDLE) quarter <= 2'd0;
            else if (tick)     quarter <= quarter + 2'd1;

            // Every state is entered at bit 7; only multi-bit states count down.
            if (state_nxt != state) bit_cnt <= 3'd7;
            else if (q_end)         bit_cnt <= bit_cnt - 3'd1;

            done <= (state == STOP) && q_end;

            if (accept)
                ack_err <= 1'b0;
            else if (sample && iSDA && (state == ADDR_ACK || state == WDATA_ACK))
                ack_err <= 1'b1;

            if (state == RDATA && q_end && last_bit) rdata <= rx_shift;
        end
    end

    // Command payload and receive shifter carry no reset: they are always
    // written before they are used.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_byte <= {cmd_addr, cmd_rw};
            wdata_reg <= cmd_wdata;
        end
        if (state == RDATA && sample) rx_shift <= {rx_shift[6:0], iSDA};
    end

endmodule
